pipelined_datapath: RTL and testbench
=====================================

Name: pipelined_datapath

Overview:
Two-stage successor to the single-cycle RV32 datapath, with width and register count parametrised.
- EX stage: register-file read, operand forwarding, B-operand mux and ALU.
- WB stage: writes the register file, or waits for a data-memory read with a valid handshake.
- Sits between the control unit (which drives the instruction fields and the handshake) and the data memory.

Parameters:
XLEN, 32, datapath/register width in bits
NREG, 32, number of architectural registers (power of 2, ≥2); register 0 hardwired to zero
AW, $clog2(NREG), register address width (derived, not overridable)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  EX instruction fields valid
in_ready  out  1  EX can accept this cycle
FS  in  4  ALU op {funct3, bit30}
use_imm  in  1  ALU B = imm when 1, else rs2
is_load  in  1  WB writes memory data instead of ALU result
reg_we  in  1  instruction writes rd
imm  in  XLEN  immediate
rs1_addr  in  AW  source 1
rs2_addr  in  AW  source 2
rd_addr  in  AW  destination
o_alu  out  XLEN  EX ALU result, combinational (store address)
zcnv  out  4  {Z,C,N,V} of EX ALU result, combinational
o_rs2  out  XLEN  forwarded rs2 value (store data), combinational
dmem_addr  out  XLEN  load address = WB-registered ALU result
dmem_req  out  1  load pending in WB
dmem_rdata  in  XLEN  load data
dmem_rvalid  in  1  load data valid this cycle
wb_commit  out  1  WB retires this cycle

Behaviour:
- Reset (synchronous, active-high): wb_valid=0, all registers=0, WB pipe registers=0. Consequently dmem_req=0, wb_commit=0, in_ready=1.
- ALU (FS): 0000 ADD, 0001 SUB, 0010 SLL, 0100 SLT, 0110 SLTU, 1000 XOR, 1010 SRL, 1011 SRA, 1100 OR, 1110 AND. All other codes give result 0.
- ALU shifts use B[$clog2(XLEN)-1:0].
- Flags:
  - Z: result==0.
  - N: result MSB.
  - C/V: carry-out and signed overflow of ADD/SUB; 0 for other ops.
  - SUB C = no-borrow (A>=B unsigned).
- Accept: fire = in_valid & in_ready. On fire, WB regs load {1, is_load, reg_we, rd_addr, o_alu}; otherwise wb_valid clears when the entry commits.
- Commit:
  - wb_commit = wb_valid & (~wb_is_load | dmem_rvalid).
  - wb_wdata = wb_is_load ? dmem_rdata : wb_alu.
  - Register write occurs when wb_commit & wb_we & wb_rd!=0.
- in_ready = ~wb_valid | wb_commit. Back-to-back issue allowed; a pending load blocks EX until dmem_rvalid.
- dmem_req = wb_valid & wb_is_load. dmem_rvalid without dmem_req is ignored. dmem_rdata is sampled only in the cycle dmem_rvalid is high.
- Latency: ALU ops write 1 cycle after fire. Loads write in the cycle dmem_rvalid is high, earliest 1 cycle after fire.
- Reads:
  - Address 0 reads 0.
  - If wb_commit & wb_we & wb_rd==rsX & rsX!=0, operand = wb_wdata (forwarding; same-cycle write wins over stale file).
- Write to register 0 is dropped.
- Reset asserted mid-load: pending load discarded, no write, dmem_req low next cycle.

Optional Feature:
Macro PDP_BYPASS_EN.
- Defined: forwarding as above.
- Undefined:
  - No forwarding; the register-file read returns the stored value only.
  - in_ready is additionally forced 0 while wb_valid & wb_we & wb_rd!=0 & wb_rd matches rs1_addr, or matches rs2_addr when (~use_imm | store-data use).
  - For simplicity, any rs2 match stalls. The instruction issues the cycle after commit.

Decomposition:
- Package pipelined_datapath_pkg: FS opcode localparams, flag bit indices (Z=3, C=2, N=1, V=0).
- One sub-module: pdp_regfile (NREG×XLEN, two combinational read ports, one synchronous write port, sync reset clears all).
- ALU stays inline in an always_comb case.

Test Plan:
- Reset, then ADD x1=x0+imm 5 (use_imm) → wb_commit next cycle; later rs1=x1 reads 5; zcnv=0000 during EX.
- Back-to-back: x2=x1+imm 3 then x3=x2+x2 → second EX sees forwarded 8, o_alu=16, in_ready stays 1.
  - Without PDP_BYPASS_EN: in_ready low 1 cycle, same result.
- SUB 5−5 → zcnv Z=1, C=1; SUB 0−1 → result 0xFFFFFFFF, N=1, C=0; ADD 0x7FFFFFFF+1 → V=1, N=1.
- Load x4 with dmem_rvalid delayed 3 cycles (rdata 0xA5A5A5A5):
  - dmem_req high 3 cycles, in_ready low 3 cycles.
  - Dependent ADD x5=x4+0 accepted in the rvalid cycle → o_alu 0xA5A5A5A5.
- Write imm 7 to x0 → x0 still reads 0. rst during pending load → no write, wb_commit 0, dmem_req 0.
- XLEN=16, NREG=8: SRA 0x8000 by 15 → 0xFFFF; SLTU 1<0xFFFF → 1.

Source files
------------

// File: rtl/pipelined_datapath_pkg.sv
// Shared constants for the two-stage datapath: ALU operation codes and flag bit positions.
// Latency: none, declarations only.
// Backpressure: not applicable.
package pipelined_datapath_pkg;

    // ALU operation select, encoded as {funct3, bit30}
    localparam logic [3:0] FS_ADD  = 4'b0000;
    localparam logic [3:0] FS_SUB  = 4'b0001;
    localparam logic [3:0] FS_SLL  = 4'b0010;
    localparam logic [3:0] FS_SLT  = 4'b0100;
    localparam logic [3:0] FS_SLTU = 4'b0110;
    localparam logic [3:0] FS_XOR  = 4'b1000;
    localparam logic [3:0] FS_SRL  = 4'b1010;
    localparam logic [3:0] FS_SRA  = 4'b1011;
    localparam logic [3:0] FS_OR   = 4'b1100;
    localparam logic [3:0] FS_AND  = 4'b1110;

    // Bit positions inside the {Z,C,N,V} flag vector
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/pdp_regfile.sv
// Architectural register file, NREG x XLEN, register 0 reads as zero.
// Latency: reads are combinational; a write is visible to reads the cycle after it is presented.
// Backpressure: none, the write port is accepted every cycle.
//
// Ports: clk/rst (sync active-high reset clears every register),
//        ra1_i/ra2_i -> rd1_o/rd2_o read ports, we_i/wa_i/wd_i write port.
module pdp_regfile #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1_i,
    input  logic [AW-1:0]   ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [AW-1:0]   wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] regs_q [NREG];

    // Writes to register 0 are discarded so its storage always stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/pipelined_datapath.sv
// Two-stage RV32-style datapath: EX (register read, forwarding, ALU) and WB (register write / load wait).
// Latency: ALU results are written 1 cycle after issue; loads are written in the cycle dmem_rvalid arrives.
// Backpressure: in_ready drops while a load waits in WB, and also on a WB register hazard when PDP_BYPASS_EN is undefined.
//
// Ports: clk/rst (sync active-high), in_valid/in_ready issue handshake, FS/use_imm/is_load/reg_we/imm/
//        rs1_addr/rs2_addr/rd_addr instruction fields, o_alu/zcnv/o_rs2 combinational EX results,
//        dmem_addr/dmem_req/dmem_rdata/dmem_rvalid load interface, wb_commit WB retire strobe.
// Build option: define PDP_BYPASS_EN to forward the committing WB value into EX instead of stalling.
module pipelined_datapath
    import pipelined_datapath_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      FS,
    input  logic            use_imm,
    input  logic            is_load,
    input  logic            reg_we,
    input  logic [XLEN-1:0] imm,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   rd_addr,
    output logic [XLEN-1:0] o_alu,
    output logic [3:0]      zcnv,
    output logic [XLEN-1:0] o_rs2,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_req,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_rvalid,
    output logic            wb_commit
);

    localparam int SW = $clog2(XLEN);

    // WB pipe registers
    logic            wb_valid_q, wb_valid_d;
    logic            wb_is_load_q, wb_is_load_d;
    logic            wb_we_q, wb_we_d;
    logic [AW-1:0]   wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_alu_q, wb_alu_d;

    logic            commit;
    logic            rf_we;
    logic            fire;
    logic [XLEN-1:0] wb_wdata;
    logic [XLEN-1:0] rf_rd1, rf_rd2;
    logic [XLEN-1:0] op_a, op_b, rs2_val;
    logic [XLEN:0]   sum_ext;
    logic [XLEN-1:0] alu_r;
    logic            alu_c, alu_v;

    // ---------------- WB stage ----------------
    assign commit   = wb_valid_q & (~wb_is_load_q | dmem_rvalid);
    assign wb_wdata = wb_is_load_q ? dmem_rdata : wb_alu_q;
    assign rf_we    = commit & wb_we_q & (wb_rd_q != '0);

    pdp_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (rs1_addr),
        .ra2_i (rs2_addr),
        .rd1_o (rf_rd1),
        .rd2_o (rf_rd2),
        .we_i  (rf_we),
        .wa_i  (wb_rd_q),
        .wd_i  (wb_wdata)
    );

    // ---------------- operand selection and issue control ----------------
`ifdef PDP_BYPASS_EN
    // The value retiring this cycle is newer than the file contents; rf_we already
    // excludes rd==0, so a match here never aliases register 0.
    assign op_a     = (rf_we && (wb_rd_q == rs1_addr)) ? wb_wdata : rf_rd1;
    assign rs2_val  = (rf_we && (wb_rd_q == rs2_addr)) ? wb_wdata : rf_rd2;
    assign in_ready = ~wb_valid_q | commit;
`else
    logic hazard;

    // Without forwarding, any source that names the pending destination must wait
    // until the write has landed in the file. rs2 is checked even for immediate ops
    // because it may still be needed as store data.
    assign hazard   = wb_valid_q & wb_we_q & (wb_rd_q != '0) &
                      ((wb_rd_q == rs1_addr) | (wb_rd_q == rs2_addr));
    assign op_a     = rf_rd1;
    assign rs2_val  = rf_rd2;
    assign in_ready = (~wb_valid_q | commit) & ~hazard;
`endif

    assign op_b = use_imm ? imm : rs2_val;
    assign fire = in_valid & in_ready;

    // ---------------- ALU ----------------
    always_comb begin
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum_ext = '0;
        case (FS)
            FS_ADD: begin
                sum_ext = {1'b0, op_a} + {1'b0, op_b};
                alu_r   = sum_ext[XLEN-1:0];
                alu_c   = sum_ext[XLEN];
                alu_v   = (op_a[XLEN-1] == op_b[XLEN-1]) && (alu_r[XLEN-1] != op_a[XLEN-1]);
            end
            FS_SUB: begin
                // A + ~B + 1: the carry out is set exactly when no borrow occurs (A >= B unsigned)
                sum_ext = {1'b0, op_a} + {1'b0, ~op_b} + (XLEN+1)'(1);
                alu_r   = sum_ext[XLEN-1:0];
                alu_c   = sum_ext[XLEN];
                alu_v   = (op_a[XLEN-1] != op_b[XLEN-1]) && (alu_r[XLEN-1] != op_a[XLEN-1]);
            end
            FS_SLL:  alu_r = op_a << op_b[SW-1:0];
            FS_SLT:  alu_r = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            FS_SLTU: alu_r = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            FS_XOR:  alu_r = op_a ^ op_b;
            FS_SRL:  alu_r = op_a >> op_b[SW-1:0];
            FS_SRA:  alu_r = $unsigned($signed(op_a) >>> op_b[SW-1:0]);
            FS_OR:   alu_r = op_a | op_b;
            FS_AND:  alu_r = op_a & op_b;
            default: alu_r = '0;
        endcase
    end

    always_comb begin
        zcnv         = '0;
        zcnv[FLAG_Z] = (alu_r == '0);
        zcnv[FLAG_C] = alu_c;
        zcnv[FLAG_N] = alu_r[XLEN-1];
        zcnv[FLAG_V] = alu_v;
    end

    assign o_alu = alu_r;
    assign o_rs2 = rs2_val;

    // ---------------- WB register update ----------------
    always_comb begin
        wb_valid_d   = wb_valid_q;
        wb_is_load_d = wb_is_load_q;
        wb_we_d      = wb_we_q;
        wb_rd_d      = wb_rd_q;
        wb_alu_d     = wb_alu_q;
        if (fire) begin
            wb_valid_d   = 1'b1;
            wb_is_load_d = is_load;
            wb_we_d      = reg_we;
            wb_rd_d      = rd_addr;
            wb_alu_d     = alu_r;
        end else if (commit) begin
            wb_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q   <= 1'b0;
            wb_is_load_q <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_alu_q     <= '0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_is_load_q <= wb_is_load_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_alu_q     <= wb_alu_d;
        end
    end

    assign dmem_addr = wb_alu_q;
    assign dmem_req  = wb_valid_q & wb_is_load_q;
    assign wb_commit = commit;

endmodule

// File: tb/tb_pipelined_datapath.sv
// Self-checking bench: 32-bit/32-register instance checked every cycle against an architectural
// model, plus a 16-bit/8-register instance checked with literal expectations.
module tb_pipelined_datapath;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // ---------------- 32-bit instance ----------------
    logic        in_valid, in_ready, use_imm, is_load, reg_we;
    logic [3:0]  fs, zcnv;
    logic [31:0] imm, o_alu, o_rs2, dmem_addr, dmem_rdata;
    logic [4:0]  rs1, rs2, rd;
    logic        dmem_req, dmem_rvalid, wb_commit;

    pipelined_datapath #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .FS(fs),
        .use_imm(use_imm), .is_load(is_load), .reg_we(reg_we), .imm(imm),
        .rs1_addr(rs1), .rs2_addr(rs2), .rd_addr(rd), .o_alu(o_alu), .zcnv(zcnv),
        .o_rs2(o_rs2), .dmem_addr(dmem_addr), .dmem_req(dmem_req),
        .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid), .wb_commit(wb_commit)
    );

    // ---------------- 16-bit instance ----------------
    logic        b_in_valid, b_in_ready, b_use_imm, b_is_load, b_reg_we;
    logic [3:0]  b_fs, b_zcnv;
    logic [15:0] b_imm, b_o_alu, b_o_rs2, b_dmem_addr, b_dmem_rdata;
    logic [2:0]  b_rs1, b_rs2, b_rd;
    logic        b_dmem_req, b_dmem_rvalid, b_wb_commit;

    pipelined_datapath #(.XLEN(16), .NREG(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .FS(b_fs),
        .use_imm(b_use_imm), .is_load(b_is_load), .reg_we(b_reg_we), .imm(b_imm),
        .rs1_addr(b_rs1), .rs2_addr(b_rs2), .rd_addr(b_rd), .o_alu(b_o_alu), .zcnv(b_zcnv),
        .o_rs2(b_o_rs2), .dmem_addr(b_dmem_addr), .dmem_req(b_dmem_req),
        .dmem_rdata(b_dmem_rdata), .dmem_rvalid(b_dmem_rvalid), .wb_commit(b_wb_commit)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- architectural model ----------------
    function automatic void alu_m(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] fl);
        longint unsigned ua   = {32'd0, a};
        longint unsigned ub   = {32'd0, b};
        longint          sa   = $signed(a);
        longint          sb   = $signed(b);
        longint          maxp = 2147483647;
        longint          minn = -maxp - 1;
        longint unsigned full;
        longint          sres;
        logic c = 1'b0;
        logic v = 1'b0;
        case (f)
            4'b0000: begin
                full = ua + ub; r = full[31:0]; c = full[32];
                sres = sa + sb; v = (sres > maxp) || (sres < minn);
            end
            4'b0001: begin
                r = a - b; c = (ua >= ub);
                sres = sa - sb; v = (sres > maxp) || (sres < minn);
            end
            4'b0010: r = a << b[4:0];
            4'b0100: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b0110: r = (ua < ub) ? 32'd1 : 32'd0;
            4'b1000: r = a ^ b;
            4'b1010: r = a >> b[4:0];
            4'b1011: begin sres = sa >>> b[4:0]; r = sres[31:0]; end
            4'b1100: r = a | b;
            4'b1110: r = a & b;
            default: r = 32'd0;
        endcase
        fl = {(r == 32'd0), c, r[31], v};
    endfunction

    logic [31:0] m_regs [32];
    logic        p_v, p_ld, p_we;
    logic [4:0]  p_rd;
    logic [31:0] p_alu;

    // Architectural view: an instruction sees every older result, including one retiring this cycle.
    always @(negedge clk) begin : model
        logic [31:0] arch [32];
        logic [31:0] mr, wd;
        logic [3:0]  mf;
        logic        cm, hz, rdy, fr;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            p_v = 1'b0; p_ld = 1'b0; p_we = 1'b0; p_rd = 5'd0; p_alu = 32'd0;
        end else begin
            cm   = p_v && (!p_ld || dmem_rvalid);
            wd   = p_ld ? dmem_rdata : p_alu;
            arch = m_regs;
            if (cm && p_we && p_rd != 5'd0) arch[p_rd] = wd;
            arch[0] = 32'd0;
`ifdef PDP_BYPASS_EN
            hz = 1'b0;
`else
            hz = p_v && p_we && (p_rd != 5'd0) && (p_rd == rs1 || p_rd == rs2);
`endif
            rdy = (!p_v || cm) && !hz;
            chk("in_ready", in_ready, rdy);
            chk("wb_commit", wb_commit, cm);
            chk("dmem_req", dmem_req, p_v && p_ld);
            if (p_v && p_ld) chk("dmem_addr", dmem_addr, p_alu);
            fr = in_valid && rdy;
            mr = 32'd0;
            if (fr) begin
                alu_m(fs, arch[rs1], use_imm ? imm : arch[rs2], mr, mf);
                chk("o_alu", o_alu, mr);
                chk("zcnv", zcnv, mf);
                chk("o_rs2", o_rs2, arch[rs2]);
            end
            m_regs = arch;
            if (fr) begin
                p_v = 1'b1; p_ld = is_load; p_we = reg_we; p_rd = rd; p_alu = mr;
            end else if (cm) begin
                p_v = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] cap_alu, cap_rs2;
    logic [3:0]  cap_z;
    logic [15:0] cap_b_alu;
    logic [3:0]  cap_b_z;

    // Called just after a rising edge; returns just after the edge on which the instruction fired.
    task automatic issue(input logic [3:0] f, input logic ui, input logic ld, input logic we,
                         input logic [31:0] im, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] d, output int st);
        logic got = 1'b0;
        fs = f; use_imm = ui; is_load = ld; reg_we = we; imm = im;
        rs1 = a1; rs2 = a2; rd = d; in_valid = 1'b1;
        st = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got = 1'b1; cap_alu = o_alu; cap_z = zcnv; cap_rs2 = o_rs2;
            end else begin
                st++;
            end
        end
        chk("issue_accept", got, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; is_load = 1'b0; reg_we = 1'b0;
    endtask

    task automatic issue_b(input logic [3:0] f, input logic [15:0] im, input logic [2:0] a1,
                           input logic [2:0] d);
        logic got = 1'b0;
        b_fs = f; b_use_imm = 1'b1; b_is_load = 1'b0; b_reg_we = 1'b1; b_imm = im;
        b_rs1 = a1; b_rs2 = 3'd0; b_rd = d; b_in_valid = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (b_in_ready === 1'b1) begin
                got = 1'b1; cap_b_alu = b_o_alu; cap_b_z = b_zcnv;
            end
        end
        chk("issue_b_accept", got, 1);
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_reg_we = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Ops against x11 = 0x80000003 with immediate 4, with hand-computed results
    localparam logic [3:0]  TFS [10] = '{4'b0010, 4'b0100, 4'b0110, 4'b1000, 4'b1010,
                                         4'b1011, 4'b1100, 4'b1110, 4'b0011, 4'b1111};
    localparam logic [31:0] TEXP [10] = '{32'h0000_0030, 32'h1, 32'h0, 32'h8000_0007, 32'h0800_0000,
                                          32'hF800_0000, 32'h8000_0007, 32'h0, 32'h0, 32'h0};

    int st, st2, exp_stall;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; use_imm = 1'b0; is_load = 1'b0; reg_we = 1'b0; fs = 4'd0; imm = 32'd0;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; dmem_rdata = 32'd0; dmem_rvalid = 1'b0;
        b_in_valid = 1'b0; b_use_imm = 1'b0; b_is_load = 1'b0; b_reg_we = 1'b0; b_fs = 4'd0;
        b_imm = 16'd0; b_rs1 = 3'd0; b_rs2 = 3'd0; b_rd = 3'd0; b_dmem_rdata = 16'd0;
        b_dmem_rvalid = 1'b0;
`ifdef PDP_BYPASS_EN
        exp_stall = 0;
`else
        exp_stall = 1;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_wb_commit", wb_commit, 0);
        chk("rst_b_in_ready", b_in_ready, 1);
        step();

        // x1 = x0 + 5, commit next cycle
        issue(4'b0000, 1, 0, 1, 32'd5, 5'd0, 5'd0, 5'd1, st);
        chk("add5_alu", cap_alu, 32'd5);
        chk("add5_zcnv", cap_z, 4'b0000);
        @(negedge clk);
        chk("add5_commit", wb_commit, 1);
        step();
        issue(4'b0000, 1, 0, 0, 32'd0, 5'd1, 5'd0, 5'd0, st);
        chk("read_x1", cap_alu, 32'd5);

        // Back-to-back dependent pair: x2 = x1 + 3; x3 = x2 + x2
        issue(4'b0000, 1, 0, 1, 32'd3, 5'd1, 5'd0, 5'd2, st);
        issue(4'b0000, 0, 0, 1, 32'd0, 5'd2, 5'd2, 5'd3, st2);
        chk("b2b_first_stall", st, 0);
        chk("b2b_alu", cap_alu, 32'd16);
        chk("b2b_rs2", cap_rs2, 32'd8);
        chk("b2b_stall", st2, exp_stall);

        // Flags
        issue(4'b0001, 1, 0, 0, 32'd5, 5'd1, 5'd0, 5'd0, st);
        chk("sub_eq_alu", cap_alu, 32'd0);
        chk("sub_eq_zcnv", cap_z, 4'b1100);
        issue(4'b0001, 1, 0, 0, 32'd1, 5'd0, 5'd0, 5'd0, st);
        chk("sub_neg_alu", cap_alu, 32'hFFFF_FFFF);
        chk("sub_neg_zcnv", cap_z, 4'b0010);
        issue(4'b0000, 1, 0, 1, 32'h7FFF_FFFF, 5'd0, 5'd0, 5'd10, st);
        issue(4'b0000, 1, 0, 0, 32'd1, 5'd10, 5'd0, 5'd0, st);
        chk("add_ovf_alu", cap_alu, 32'h8000_0000);
        chk("add_ovf_zcnv", cap_z, 4'b0011);

        // Remaining ops and unused codes
        issue(4'b0000, 1, 0, 1, 32'h8000_0003, 5'd0, 5'd0, 5'd11, st);
        for (int i = 0; i < 10; i++) begin
            issue(TFS[i], 1, 0, 0, 32'd4, 5'd11, 5'd0, 5'd0, st);
            chk("op_table", cap_alu, TEXP[i]);
        end

        // Load x4 with data arriving after 3 waiting cycles
        issue(4'b0000, 1, 1, 1, 32'h100, 5'd0, 5'd0, 5'd4, st);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ld_wait_req", dmem_req, 1);
            chk("ld_wait_ready", in_ready, 0);
            chk("ld_wait_addr", dmem_addr, 32'h100);
            step();
        end
        dmem_rvalid = 1'b1; dmem_rdata = 32'hA5A5_A5A5;
        issue(4'b0000, 1, 0, 1, 32'd0, 5'd4, 5'd0, 5'd5, st);
        dmem_rvalid = 1'b0;
        chk("ld_dep_alu", cap_alu, 32'hA5A5_A5A5);
        chk("ld_dep_stall", st, exp_stall);

        // Writes to x0 are dropped
        issue(4'b0000, 1, 0, 1, 32'd7, 5'd0, 5'd0, 5'd0, st);
        issue(4'b0000, 0, 0, 1, 32'd0, 5'd0, 5'd0, 5'd6, st);
        chk("x0_alu", cap_alu, 32'd0);
        chk("x0_rs2", cap_rs2, 32'd0);

        // Reset while a load waits
        issue(4'b0000, 1, 1, 1, 32'h200, 5'd0, 5'd0, 5'd7, st);
        rst = 1'b1;
        step();
        rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rst_ld_req", dmem_req, 0);
        chk("rst_ld_commit", wb_commit, 0);
        chk("rst_ld_ready", in_ready, 1);
        step();
        dmem_rvalid = 1'b0;
        issue(4'b0000, 1, 0, 0, 32'd0, 5'd7, 5'd0, 5'd0, st);
        chk("rst_ld_x7", cap_alu, 32'd0);
        issue(4'b0000, 1, 0, 0, 32'd0, 5'd1, 5'd0, 5'd0, st);
        chk("rst_x1_cleared", cap_alu, 32'd0);

        // 16-bit / 8-register instance (DUT A idle)
        issue_b(4'b0000, 16'h8000, 3'd0, 3'd1);
        issue_b(4'b1011, 16'd15, 3'd1, 3'd2);
        chk("b_sra_alu", cap_b_alu, 16'hFFFF);
        chk("b_sra_zcnv", cap_b_z, 4'b0010);
        issue_b(4'b0000, 16'd1, 3'd0, 3'd5);
        issue_b(4'b0110, 16'hFFFF, 3'd5, 3'd6);
        chk("b_sltu_alu", cap_b_alu, 16'd1);
        @(negedge clk);
        chk("b_dmem_addr", b_dmem_addr, 16'd1);
        chk("b_dmem_req", b_dmem_req, 0);
        chk("b_commit", b_wb_commit, 1);
        chk("b_o_rs2", b_o_rs2, 16'd0);
        step();

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
